// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file arbiter: FSM encoding,
// register word addresses and the default byte-lane count.
package regfile_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_LANE  = 3'd1,
        RD_WAIT1 = 3'd2,
        RD_WAIT2 = 3'd3,
        DONE     = 3'd4
    } state_t;

    localparam logic [2:0] CNAME    = 3'd0;
    localparam logic [2:0] VERSION  = 3'd1;
    localparam logic [2:0] STATUS   = 3'd2;
    localparam logic [2:0] PINSTATE = 3'd3;
    localparam logic [2:0] CONTROL  = 3'd4;
    localparam logic [2:0] DATAREG  = 3'd5;
    localparam logic [2:0] SCRATCH  = 3'd6;
    localparam logic [2:0] UNMAPPED = 3'd7;

    localparam int NUM_LANES = 4;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant; the last-grant flop only moves while enabled.
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en_i,
    input  logic [1:0] req_i,
    output logic [1:0] grant_o
);

    logic last_q;
    logic last_d;

    always_comb begin
        grant_o = 2'b00;
        if (en_i) begin
            case (req_i)
                2'b01:   grant_o = 2'b01;
                2'b10:   grant_o = 2'b10;
                2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
                default: grant_o = 2'b00;
            endcase
        end
        last_d = last_q;
        if (grant_o[1]) begin
            last_d = 1'b1;
        end else if (grant_o[0]) begin
            last_d = 1'b0;
        end
    end

    // Reset value 1 makes requester 0 win the first tie.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Arbitrates two requesters onto a register-file command bus; writes are
// split into one bus cycle per enabled byte lane, reads wait two edges.
//   state    | meaning
//   IDLE     | bus idle, sampling requests
//   WR_LANE  | issuing one enabled lane per cycle
//   RD_WAIT1 | read command on bus
//   RD_WAIT2 | read data arrives at next edge
//   DONE     | one-cycle done pulse to owner
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int NLANES = NUM_LANES
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq0_valid,
    input  logic              rq0_write,
    input  logic [4:2]        rq0_addr,
    input  logic [NLANES-1:0] rq0_be,
    input  logic [31:0]       rq0_wdata,
    output logic              rq0_done,
    output logic [31:0]       rq0_rdata,
    input  logic              rq1_valid,
    input  logic              rq1_write,
    input  logic [4:2]        rq1_addr,
    input  logic [NLANES-1:0] rq1_be,
    input  logic [31:0]       rq1_wdata,
    output logic              rq1_done,
    output logic [31:0]       rq1_rdata,
    output logic [4:2]        rf_addr,
    output logic [1:0]        rf_wben,
    output logic              rf_r_wn,
    output logic [31:0]       rf_wdata,
    input  logic [31:0]       rf_rdata
);

    localparam int LW = $clog2(NLANES) + 1;

    state_t            state_q;
    logic              owner_q;
    logic [4:2]        addr_q;
    logic [NLANES-1:0] be_q;
    logic [31:0]       wdata_q;
    logic [LW-1:0]     lane_q;
    logic [1:0]        block_q;
    logic [1:0]        done_q;
    logic [31:0]       rdata0_q;
    logic [31:0]       rdata1_q;
    logic [4:2]        rf_addr_q;
    logic [1:0]        rf_wben_q;
    logic              rf_r_wn_q;
    logic [31:0]       rf_wdata_q;

    logic [1:0]        grant;
    logic              sel_write;
    logic [4:2]        sel_addr;
    logic [NLANES-1:0] sel_be;
    logic [31:0]       sel_wdata;
    logic              nxt_found;
    logic [LW-1:0]     nxt_lane;
    logic [1:0]        owner_oh;
    logic [31:0]       cap_data;

    // The requester that just finished is masked for one IDLE cycle.
    rr_arb2 u_arb (
        .clk     (clk),
        .reset   (reset),
        .en_i    (state_q == IDLE),
        .req_i   ({rq1_valid, rq0_valid} & ~block_q),
        .grant_o (grant)
    );

    always_comb begin
        sel_write = grant[1] ? rq1_write : rq0_write;
        sel_addr  = grant[1] ? rq1_addr  : rq0_addr;
        sel_be    = grant[1] ? rq1_be    : rq0_be;
        sel_wdata = grant[1] ? rq1_wdata : rq0_wdata;
        owner_oh  = owner_q ? 2'b10 : 2'b01;
        cap_data  = (addr_q == UNMAPPED) ? 32'h0 : rf_rdata;
    end

    // Lowest enabled lane at or above the lane pointer.
    always_comb begin
        nxt_found = 1'b0;
        nxt_lane  = '0;
        for (int i = NLANES - 1; i >= 0; i--) begin
            if (be_q[i] && (LW'(i) >= lane_q)) begin
                nxt_found = 1'b1;
                nxt_lane  = LW'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            lane_q     <= '0;
            block_q    <= 2'b00;
            done_q     <= 2'b00;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
            rf_addr_q  <= '0;
            rf_wben_q  <= '0;
            rf_r_wn_q  <= 1'b1;
            rf_wdata_q <= '0;
        end else begin
            done_q  <= 2'b00;
            block_q <= 2'b00;
            case (state_q)
                IDLE: begin
                    if (|grant) begin
                        owner_q <= grant[1];
                        addr_q  <= sel_addr;
                        be_q    <= sel_be;
                        wdata_q <= sel_wdata;
                        lane_q  <= '0;
                        if (sel_write) begin
                            state_q <= WR_LANE;
                        end else begin
                            rf_r_wn_q <= 1'b1;
                            rf_addr_q <= sel_addr;
                            state_q   <= RD_WAIT1;
                        end
                    end
                end
                WR_LANE: begin
                    if (nxt_found) begin
                        rf_r_wn_q  <= 1'b0;
                        rf_addr_q  <= addr_q;
                        rf_wben_q  <= 2'(nxt_lane);
                        rf_wdata_q <= wdata_q;
                        lane_q     <= nxt_lane + LW'(1);
                    end else begin
                        rf_r_wn_q  <= 1'b1;
                        rf_addr_q  <= '0;
                        rf_wben_q  <= '0;
                        rf_wdata_q <= '0;
                        done_q     <= owner_oh;
                        state_q    <= DONE;
                    end
                end
                RD_WAIT1: state_q <= RD_WAIT2;
                RD_WAIT2: begin
                    if (owner_q) begin
                        rdata1_q <= cap_data;
                    end else begin
                        rdata0_q <= cap_data;
                    end
                    rf_addr_q <= '0;
                    done_q    <= owner_oh;
                    state_q   <= DONE;
                end
                DONE: begin
                    block_q <= owner_oh;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rq0_done  = done_q[0];
    assign rq1_done  = done_q[1];
    assign rq0_rdata = rdata0_q;
    assign rq1_rdata = rdata1_q;
    assign rf_addr   = rf_addr_q;
    assign rf_wben   = rf_wben_q;
    assign rf_r_wn   = rf_r_wn_q;
    assign rf_wdata  = rf_wdata_q;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Scoreboard bench for regfile_arbiter with a behavioural register file.
module tb_regfile_arbiter;
    import regfile_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rq0_valid = 1'b0, rq0_write = 1'b0;
    logic [4:2]  rq0_addr = '0;
    logic [3:0]  rq0_be = '0;
    logic [31:0] rq0_wdata = '0;
    logic        rq1_valid = 1'b0, rq1_write = 1'b0;
    logic [4:2]  rq1_addr = '0;
    logic [3:0]  rq1_be = '0;
    logic [31:0] rq1_wdata = '0;
    logic        rq0_done, rq1_done;
    logic [31:0] rq0_rdata, rq1_rdata;
    logic [4:2]  rf_addr;
    logic [1:0]  rf_wben;
    logic        rf_r_wn;
    logic [31:0] rf_wdata;
    logic [31:0] rf_rdata = '0;
    logic [15:0] pinstate = 16'hBEEF;
    logic [31:0] regs [8] = '{32'h48524a44, 32'h00010002, 32'h00000000, 32'h00000000,
                              32'h00000000, 32'hCAFE0005, 32'h00000000, 32'h00000000};

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        bit          is_rd;
        logic [31:0] rdata;
        int          lat;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [2:0]  addr;
        logic [1:0]  lane;
        logic [31:0] wdata;
    } wr_t;
    wr_t wr_log[$];

    regfile_arbiter #(.NLANES(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .rq0_valid (rq0_valid),
        .rq0_write (rq0_write),
        .rq0_addr  (rq0_addr),
        .rq0_be    (rq0_be),
        .rq0_wdata (rq0_wdata),
        .rq0_done  (rq0_done),
        .rq0_rdata (rq0_rdata),
        .rq1_valid (rq1_valid),
        .rq1_write (rq1_write),
        .rq1_addr  (rq1_addr),
        .rq1_be    (rq1_be),
        .rq1_wdata (rq1_wdata),
        .rq1_done  (rq1_done),
        .rq1_rdata (rq1_rdata),
        .rf_addr   (rf_addr),
        .rf_wben   (rf_wben),
        .rf_r_wn   (rf_r_wn),
        .rf_wdata  (rf_wdata),
        .rf_rdata  (rf_rdata)
    );

    always #5 clk = ~clk;

    // Register file: read data registered one edge after the command;
    // only CONTROL, DATAREG and SCRATCH accept byte writes.
    always @(posedge clk) begin
        case (rf_addr)
            PINSTATE: rf_rdata <= {16'h0, pinstate};
            UNMAPPED: rf_rdata <= 32'hDEADDEAD;
            default:  rf_rdata <= regs[rf_addr];
        endcase
        if (rf_r_wn === 1'b0 && (rf_addr inside {CONTROL, DATAREG, SCRATCH}))
            regs[rf_addr][int'(rf_wben)*8 +: 8] <= rf_wdata[int'(rf_wben)*8 +: 8];
    end

    always @(negedge clk) begin
        if (!reset && rf_r_wn === 1'b0)
            wr_log.push_back('{rf_addr, rf_wben, rf_wdata});
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    // Runs one request to completion; payload is scrambled after the grant edge.
    task automatic do_req(input int id, input logic wr, input logic [2:0] a,
                          input logic [3:0] be, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic done_after);
        @(negedge clk);
        if (id == 0) begin
            rq0_write = wr; rq0_addr = a; rq0_be = be; rq0_wdata = wd; rq0_valid = 1'b1;
        end else begin
            rq1_write = wr; rq1_addr = a; rq1_be = be; rq1_wdata = wd; rq1_valid = 1'b1;
        end
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                if (id == 0) begin
                    rq0_addr = a ^ 3'b101; rq0_be = ~be; rq0_wdata = ~wd;
                end else begin
                    rq1_addr = a ^ 3'b101; rq1_be = ~be; rq1_wdata = ~wd;
                end
            end
        end while (!((id == 0) ? rq0_done : rq1_done) && lat < 40);
        rd = (id == 0) ? rq0_rdata : rq1_rdata;
        if (id == 0) rq0_valid = 1'b0; else rq1_valid = 1'b0;
        @(negedge clk);
        done_after = (id == 0) ? rq0_done : rq1_done;
        @(negedge clk);
    endtask

    task automatic run_expected();
        exp_t e;
        int lat;
        logic [31:0] rd;
        logic da;
        e = exp_q[0];
        do_req(e.id, !e.is_rd, 3'd0, 4'd0, 32'd0, lat, rd, da);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({rf_r_wn, rf_addr, rf_wben, rf_wdata} !== {1'b1, 3'b0, 2'b0, 32'b0}) begin
            errors++;
            $display("FAIL reset_bus: got r_wn=%b addr=%0d wben=%0d wdata=%h, expected idle",
                     rf_r_wn, rf_addr, rf_wben, rf_wdata);
        end
        checks++;
        if ({rq0_done, rq1_done, rq0_rdata, rq1_rdata} !== 66'b0) begin
            errors++;
            $display("FAIL reset_outputs: got done=%b%b rdata0=%h rdata1=%h, expected zeros",
                     rq0_done, rq1_done, rq0_rdata, rq1_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        int got;
        int seen;
        exp_t e;
        wr_log.delete();
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            rq0_write = 1'b1; rq0_addr = SCRATCH; rq0_be = 4'b0001; rq0_wdata = 32'h000000A0 + r;
            rq1_write = 1'b1; rq1_addr = SCRATCH; rq1_be = 4'b0010; rq1_wdata = 32'h0000B000;
            rq0_valid = 1'b1; rq1_valid = 1'b1;
            exp_q.push_back('{0, 1'b0, 32'h0, 0});
            exp_q.push_back('{1, 1'b0, 32'h0, 0});
            seen = 0;
            for (int c = 0; c < 40 && seen < 2; c++) begin
                @(negedge clk);
                got = -1;
                if (rq0_done) begin got = 0; rq0_valid = 1'b0; end
                else if (rq1_done) begin got = 1; rq1_valid = 1'b0; end
                if (got >= 0) begin
                    e = exp_q.pop_front();
                    seen++;
                    checks++;
                    if (got !== e.id) begin
                        errors++;
                        $display("FAIL rr_order: round %0d got requester %0d, expected %0d", r, got, e.id);
                    end
                end
            end
            checks++;
            if (seen != 2) begin
                errors++;
                $display("FAIL rr_timeout: round %0d got %0d completions, expected 2", r, seen);
                exp_q.delete();
                rq0_valid = 1'b0; rq1_valid = 1'b0;
            end
            repeat (2) @(negedge clk);
        end
        checks++;
        if (wr_log.size() != 4) begin
            errors++;
            $display("FAIL rr_lane_count: got %0d lane cycles, expected 4", wr_log.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_log[i].lane !== 2'(i % 2)) begin
                    errors++;
                    $display("FAIL rr_lane_seq: cycle %0d got lane %0d, expected %0d", i, wr_log[i].lane, i % 2);
                end
            end
        end
    endtask

    task automatic test_read();
        int lat; logic [31:0] rd; logic da; exp_t e;
        exp_q.push_back('{0, 1'b1, 32'h48524a44, 3});
        do_req(0, 1'b0, CNAME, 4'h0, 32'h0, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL read_latency: got %0d, expected %0d", lat, e.lat); end
        checks++;
        if (rd !== e.rdata) begin errors++; $display("FAIL read_cname: got %h, expected %h", rd, e.rdata); end
        checks++;
        if (da !== 1'b0) begin errors++; $display("FAIL done_width: got done=%b after pulse, expected 0", da); end
    endtask

    task automatic test_write_lanes();
        int lat; logic [31:0] rd; logic da; exp_t e;
        wr_log.delete();
        exp_q.push_back('{1, 1'b0, 32'h0, 6});
        do_req(1, 1'b1, SCRATCH, 4'b1111, 32'h11223344, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL wr4_latency: got %0d, expected %0d", lat, e.lat); end
        checks++;
        if (wr_log.size() != 4) begin errors++; $display("FAIL wr4_lanes: got %0d, expected 4", wr_log.size()); end

        wr_log.delete();
        exp_q.push_back('{1, 1'b0, 32'h0, 4});
        do_req(1, 1'b1, SCRATCH, 4'b1010, 32'hA1B2C3D4, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL wr2_latency: got %0d, expected %0d", lat, e.lat); end
        checks++;
        if (wr_log.size() != 2) begin
            errors++;
            $display("FAIL wr2_lanes: got %0d lane cycles, expected 2", wr_log.size());
        end else begin
            checks++;
            if ({wr_log[0].addr, wr_log[0].lane, wr_log[1].addr, wr_log[1].lane} !== {SCRATCH, 2'd1, SCRATCH, 2'd3}) begin
                errors++;
                $display("FAIL wr2_order: got %0d/%0d then %0d/%0d, expected 6/1 then 6/3",
                         wr_log[0].addr, wr_log[0].lane, wr_log[1].addr, wr_log[1].lane);
            end
            checks++;
            if (wr_log[0].wdata !== 32'hA1B2C3D4 || wr_log[1].wdata !== 32'hA1B2C3D4) begin
                errors++;
                $display("FAIL wr2_wdata: got %h/%h, expected a1b2c3d4", wr_log[0].wdata, wr_log[1].wdata);
            end
        end

        exp_q.push_back('{1, 1'b1, 32'hA122C344, 3});
        do_req(1, 1'b0, SCRATCH, 4'h0, 32'h0, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || lat != e.lat) begin
            errors++;
            $display("FAIL wr2_readback: got %h lat %0d, expected %h lat %0d", rd, lat, e.rdata, e.lat);
        end
    endtask

    task automatic test_be_zero();
        int lat; logic [31:0] rd; logic da; exp_t e;
        wr_log.delete();
        exp_q.push_back('{0, 1'b0, 32'h0, 2});
        do_req(0, 1'b1, DATAREG, 4'b0000, 32'hFFFFFFFF, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (lat != e.lat) begin errors++; $display("FAIL be0_latency: got %0d, expected %0d", lat, e.lat); end
        checks++;
        if (wr_log.size() != 0) begin errors++; $display("FAIL be0_bus: got %0d write cycles, expected 0", wr_log.size()); end
        exp_q.push_back('{0, 1'b1, 32'hCAFE0005, 3});
        do_req(0, 1'b0, DATAREG, 4'h0, 32'h0, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata) begin errors++; $display("FAIL be0_datareg: got %h, expected %h", rd, e.rdata); end
    endtask

    task automatic test_unmapped_pinstate();
        int lat; logic [31:0] rd; logic da; exp_t e;
        exp_q.push_back('{1, 1'b1, 32'h0, 3});
        do_req(1, 1'b0, UNMAPPED, 4'h0, 32'h0, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || lat != e.lat) begin
            errors++;
            $display("FAIL unmapped_read: got %h lat %0d, expected %h lat %0d", rd, lat, e.rdata, e.lat);
        end
        checks++;
        if (rq0_rdata !== 32'hCAFE0005) begin
            errors++;
            $display("FAIL rdata_hold: got rq0_rdata %h, expected cafe0005", rq0_rdata);
        end
        exp_q.push_back('{0, 1'b1, 32'h0000BEEF, 3});
        do_req(0, 1'b0, PINSTATE, 4'h0, 32'h0, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata) begin errors++; $display("FAIL pinstate_read: got %h, expected %h", rd, e.rdata); end
    endtask

    task automatic test_reset_mid_write();
        int lat; logic [31:0] rd; logic da; bit hit; bit saw_done; exp_t e;
        @(negedge clk);
        rq0_write = 1'b1; rq0_addr = SCRATCH; rq0_be = 4'b1111; rq0_wdata = 32'h99887766; rq0_valid = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 20 && !hit; c++) begin
            @(negedge clk);
            if (rf_r_wn === 1'b0 && rf_wben === 2'd2) hit = 1'b1;
        end
        checks++;
        if (!hit) begin errors++; $display("FAIL midwr_lane2: got no lane-2 cycle, expected one"); end
        reset = 1'b1;
        #1;
        checks++;
        if ({rf_r_wn, rf_addr, rf_wben, rf_wdata, rq0_done, rq0_rdata} !== {1'b1, 3'b0, 2'b0, 32'b0, 1'b0, 32'b0}) begin
            errors++;
            $display("FAIL midwr_idle: got r_wn=%b addr=%0d wben=%0d wdata=%h done=%b rdata=%h, expected idle/zero",
                     rf_r_wn, rf_addr, rf_wben, rf_wdata, rq0_done, rq0_rdata);
        end
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rq0_done) saw_done = 1'b1;
        end
        rq0_valid = 1'b0;
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (rq0_done) saw_done = 1'b1;
        end
        checks++;
        if (saw_done) begin errors++; $display("FAIL midwr_nodone: got done pulse, expected none"); end
        exp_q.push_back('{0, 1'b1, 32'hA1227766, 3});
        do_req(0, 1'b0, SCRATCH, 4'h0, 32'h0, lat, rd, da);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e.rdata || lat != e.lat) begin
            errors++;
            $display("FAIL midwr_scratch: got %h lat %0d, expected %h lat %0d", rd, lat, e.rdata, e.lat);
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_read();
        test_write_lanes();
        test_be_zero();
        test_unmapped_pinstate();
        test_reset_mid_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
